// File: rtl/ft_recovery_seq.sv
// ---------------------------------------------------------------------------
// ft_recovery_seq
//
// Recovery sequencer for the dual-core lockstep SoC. It sits downstream of
// the lockstep comparator and keeps a shadow checkpoint of x1..x31, built
// from the committed regfile writes of core 0. When the comparator reports
// a mismatch, it halts both cores and writes every GPR plus the checkpoint
// NPC into both cores through their debug ports. Each core has its own
// request/grant handshake. When the writes are done, it resumes the cores.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rf_we_i/waddr_i/wdata_i core 0 committed regfile write port
//   pc_i                   core 0 instruction address (checkpoint PC)
//   error_i                comparator mismatch pulse
//   debug_halt_o           1-cycle halt request to both cores
//   debug_resume_o         1-cycle resume request to both cores
//   debug_req_k_o          per-core debug write request
//   debug_gnt_k_i          per-core debug write grant
//   debug_halted_k_i       per-core halted status
//   debug_we_o/addr_o/wdata_o shared debug write beat
//   busy_o                 sequencer not idle
//   timeout_o              sticky: cores never reported halted
//   recover_cnt_o          completed recoveries, saturating at 255
// ---------------------------------------------------------------------------
module ft_recovery_seq #(
    parameter logic [14:0] DBG_GPR_BASE = 15'h0400,
    parameter logic [14:0] DBG_NPC_ADDR = 15'h2000,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rf_we_i,
    input  logic [4:0]  rf_waddr_i,
    input  logic [31:0] rf_wdata_i,
    input  logic [31:0] pc_i,
    input  logic        error_i,
    output logic        debug_halt_o,
    output logic        debug_resume_o,
    output logic        debug_req_0_o,
    output logic        debug_req_1_o,
    input  logic        debug_gnt_0_i,
    input  logic        debug_gnt_1_i,
    input  logic        debug_halted_0_i,
    input  logic        debug_halted_1_i,
    output logic        debug_we_o,
    output logic [14:0] debug_addr_o,
    output logic [31:0] debug_wdata_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [7:0]  recover_cnt_o
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HALT      = 3'd1;
    localparam logic [2:0] ST_WAIT_HALT = 3'd2;
    localparam logic [2:0] ST_WR_GPR    = 3'd3;
    localparam logic [2:0] ST_WR_NPC    = 3'd4;
    localparam logic [2:0] ST_RESUME    = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    localparam logic [7:0] TMO_LAST = 8'(HALT_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        done_0_q, done_0_d;
    logic        done_1_q, done_1_d;
    logic [31:0] ckpt_pc_q, ckpt_pc_d;
    logic [7:0]  recover_cnt_q, recover_cnt_d;
    logic [31:0] shadow_q [1:31];
    logic [31:0] shadow_d [1:31];

    logic in_beat;
    logic beat_done;

    assign in_beat = (state_q == ST_WR_GPR) || (state_q == ST_WR_NPC);

    // A core counts as finished with this beat if it accepted earlier
    // (done flag) or is granting right now while its request is high.
    assign beat_done = in_beat && (done_0_q || debug_gnt_0_i)
                               && (done_1_q || debug_gnt_1_i);

    // Shadow checkpoint. It is only built while idle. A write that coincides
    // with the mismatch pulse may be the faulty result, so it is dropped.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if ((state_q == ST_IDLE) && rf_we_i && (rf_waddr_i != 5'd0) && !error_i) begin
            shadow_d[rf_waddr_i] = rf_wdata_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tmo_cnt_d     = tmo_cnt_q;
        done_0_d      = done_0_q;
        done_1_d      = done_1_q;
        ckpt_pc_d     = ckpt_pc_q;
        recover_cnt_d = recover_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (error_i) begin
                    state_d   = ST_HALT;
                    ckpt_pc_d = pc_i;
                end
            end
            ST_HALT: begin
                tmo_cnt_d = 8'd0;
                state_d   = ST_WAIT_HALT;
            end
            ST_WAIT_HALT: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (debug_halted_0_i && debug_halted_1_i) begin
                    state_d  = ST_WR_GPR;
                    idx_d    = 5'd1;
                    done_0_d = 1'b0;
                    done_1_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            ST_WR_GPR, ST_WR_NPC: begin
                if (beat_done) begin
                    done_0_d = 1'b0;
                    done_1_d = 1'b0;
                    if (state_q == ST_WR_NPC) begin
                        state_d = ST_RESUME;
                    end else if (idx_q == 5'd31) begin
                        state_d = ST_WR_NPC;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    done_0_d = done_0_q || debug_gnt_0_i;
                    done_1_d = done_1_q || debug_gnt_1_i;
                end
            end
            ST_RESUME: begin
                if (recover_cnt_q != 8'hFF) begin
                    recover_cnt_d = recover_cnt_q + 8'd1;
                end
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            idx_q         <= 5'd0;
            tmo_cnt_q     <= 8'd0;
            done_0_q      <= 1'b0;
            done_1_q      <= 1'b0;
            ckpt_pc_q     <= 32'd0;
            recover_cnt_q <= 8'd0;
            for (int i = 1; i < 32; i++) begin
                shadow_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            done_0_q      <= done_0_d;
            done_1_q      <= done_1_d;
            ckpt_pc_q     <= ckpt_pc_d;
            recover_cnt_q <= recover_cnt_d;
            for (int i = 1; i < 32; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // All outputs decode straight from the registered state. An
    // asynchronous reset therefore drops them immediately.
    always_comb begin
        debug_addr_o  = 15'd0;
        debug_wdata_o = 32'd0;
        if (state_q == ST_WR_GPR) begin
            debug_addr_o  = DBG_GPR_BASE + {8'd0, idx_q, 2'b00};
            debug_wdata_o = shadow_q[idx_q];
        end else if (state_q == ST_WR_NPC) begin
            debug_addr_o  = DBG_NPC_ADDR;
            debug_wdata_o = ckpt_pc_q;
        end
    end

    assign debug_we_o     = in_beat;
    assign debug_req_0_o  = in_beat && !done_0_q;
    assign debug_req_1_o  = in_beat && !done_1_q;
    assign debug_halt_o   = (state_q == ST_HALT);
    assign debug_resume_o = (state_q == ST_RESUME);
    assign busy_o         = (state_q != ST_IDLE);
    assign timeout_o      = (state_q == ST_FAIL);
    assign recover_cnt_o  = recover_cnt_q;

endmodule

// File: tb/tb_ft_recovery_seq.sv
// ---------------------------------------------------------------------------
// tb_ft_recovery_seq
//
// Directed bench for ft_recovery_seq. A reference model of the checkpoint
// (an expected register array, the PC and the recovery count) follows the
// stimulus. A per-cycle compare task checks the DUT outputs against that
// model. A grant responder with per-core skew stands in for the two cores.
// ---------------------------------------------------------------------------
module tb_ft_recovery_seq;

    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        error;
    logic        halt, resume, req0, req1, gnt0, gnt1, halted0, halted1;
    logic        we, busy, tmo_flag;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [7:0]  rcnt;

    always #5 clk = ~clk;

    ft_recovery_seq #(
        .DBG_GPR_BASE (15'h0400),
        .DBG_NPC_ADDR (15'h2000),
        .HALT_TIMEOUT (TMO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rf_we_i          (rf_we),
        .rf_waddr_i       (rf_waddr),
        .rf_wdata_i       (rf_wdata),
        .pc_i             (pc),
        .error_i          (error),
        .debug_halt_o     (halt),
        .debug_resume_o   (resume),
        .debug_req_0_o    (req0),
        .debug_req_1_o    (req1),
        .debug_gnt_0_i    (gnt0),
        .debug_gnt_1_i    (gnt1),
        .debug_halted_0_i (halted0),
        .debug_halted_1_i (halted1),
        .debug_we_o       (we),
        .debug_addr_o     (addr),
        .debug_wdata_o    (wdata),
        .busy_o           (busy),
        .timeout_o        (tmo_flag),
        .recover_cnt_o    (rcnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model
    logic [31:0] m_shadow [0:31];
    logic [31:0] m_pc;
    int          m_cnt;
    int          phase;      // 0 idle, 1 recovery expected, 2 halt timeout expected
    int          m_start;    // cycle in which the halt pulse is due
    int          e_cyc;
    int          resume_cyc;
    bit          got_resume;

    // Core responder and per-core write logs
    int          skew0, skew1, wcnt0, wcnt1;
    logic [14:0] log0_a [$];
    logic [14:0] log1_a [$];
    logic [31:0] log0_d [$];
    logic [31:0] log1_d [$];
    bit          acc0 [0:32];
    bit          acc1 [0:32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int slot_of(input logic [14:0] a);
        if (a == 15'h2000) return 32;
        if (a >= 15'h0404 && a <= 15'h047C && a[1:0] == 2'b00) return int'((a - 15'h0400) >> 2);
        return -1;
    endfunction

    task automatic monitor();
        logic g0, g1;
        int   s;
        if (req0) begin g0 = (wcnt0 >= skew0); wcnt0 = g0 ? 0 : wcnt0 + 1; end
        else begin g0 = 1'b0; wcnt0 = 0; end
        if (req1) begin g1 = (wcnt1 >= skew1); wcnt1 = g1 ? 0 : wcnt1 + 1; end
        else begin g1 = 1'b0; wcnt1 = 0; end
        gnt0 = g0;
        gnt1 = g1;

        chk("busy", 32'(busy), 32'(phase != 0 && cyc >= m_start));
        chk("halt_pulse", 32'(halt), 32'(phase != 0 && cyc == m_start));
        chk("timeout", 32'(tmo_flag), 32'(phase == 2 && cyc >= m_start + 1 + TMO));
        chk("recover_cnt", 32'(rcnt), 32'(m_cnt));
        if (phase != 1) begin
            chk("req0_quiet", 32'(req0), 0);
            chk("req1_quiet", 32'(req1), 0);
            chk("we_quiet", 32'(we), 0);
            chk("resume_quiet", 32'(resume), 0);
        end
        if (we) begin
            s = slot_of(addr);
            chk("addr_legal", 32'(s >= 0), 1);
            if (s == 32) chk("npc_data", wdata, m_pc);
            else if (s > 0) chk("gpr_data", wdata, m_shadow[s]);
            if (s >= 0) begin
                if (req0) chk("dup_req0", 32'(acc0[s]), 0);
                if (req1) chk("dup_req1", 32'(acc1[s]), 0);
                if (req0 && g0) begin acc0[s] = 1'b1; log0_a.push_back(addr); log0_d.push_back(wdata); end
                if (req1 && g1) begin acc1[s] = 1'b1; log1_a.push_back(addr); log1_d.push_back(wdata); end
            end
        end else begin
            chk("req_without_we", 32'({req1, req0}), 0);
        end
        if (resume) begin
            if (phase == 1) chk("resume_min_latency", 32'(cyc - m_start + 1 >= 35), 1);
            resume_cyc = cyc;
            got_resume = 1'b1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            phase = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic clear_logs();
        log0_a.delete(); log1_a.delete(); log0_d.delete(); log1_d.delete();
        for (int i = 0; i < 33; i++) begin acc0[i] = 1'b0; acc1[i] = 1'b0; end
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        step();
        rf_we = 1'b0;
        if (a != 5'd0 && phase == 0) m_shadow[a] = d;
    endtask

    task automatic start_err(input logic [31:0] p, input int ph, input bit w,
                             input logic [4:0] wa, input logic [31:0] wd);
        clear_logs();
        got_resume = 1'b0;
        error = 1'b1; pc = p; rf_we = w; rf_waddr = wa; rf_wdata = wd;
        m_pc = p; m_start = cyc + 1; phase = ph; e_cyc = cyc;
        step();
        error = 1'b0; rf_we = 1'b0; pc = p + 32'h100;
    endtask

    task automatic wait_resume(input bit busy_err);
        for (int i = 0; i < 2000 && !got_resume; i++) begin
            if (busy_err && i == 5) begin
                error = 1'b1; pc = 32'h0000BAD0; rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h33;
            end
            step();
            error = 1'b0; rf_we = 1'b0;
        end
        chk("resume_seen", 32'(got_resume), 1);
        step();
    endtask

    task automatic check_logs(input string tag);
        logic [14:0] ea;
        logic [31:0] ed;
        chk({tag, "_n_core0"}, 32'(log0_a.size()), 32);
        chk({tag, "_n_core1"}, 32'(log1_a.size()), 32);
        for (int k = 0; k < 32; k++) begin
            ea = (k < 31) ? 15'(15'h0400 + 4 * (k + 1)) : 15'h2000;
            ed = (k < 31) ? m_shadow[k + 1] : m_pc;
            if (k < log0_a.size()) begin
                chk({tag, "_addr_core0"}, 32'(log0_a[k]), 32'(ea));
                chk({tag, "_data_core0"}, log0_d[k], ed);
            end
            if (k < log1_a.size()) begin
                chk({tag, "_addr_core1"}, 32'(log1_a[k]), 32'(ea));
                chk({tag, "_data_core1"}, log1_d[k], ed);
            end
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0; pc = 32'd0;
        error = 1'b0; gnt0 = 1'b0; gnt1 = 1'b0; halted0 = 1'b1; halted1 = 1'b1;
        skew0 = 0; skew1 = 0; wcnt0 = 0; wcnt1 = 0;
        phase = 0; m_cnt = 0; m_pc = 32'd0; m_start = 0; e_cyc = 0;
        resume_cyc = 0; got_resume = 1'b0;
        for (int i = 0; i < 32; i++) m_shadow[i] = 32'd0;
        clear_logs();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(tmo_flag), 0);
        chk("rst_cnt", 32'(rcnt), 0);
        chk("rst_req", 32'({req1, req0, halt, resume, we}), 0);

        // Basic recovery with immediate grants
        rf_write(5'd5, 32'hDEADBEEF);
        rf_write(5'd31, 32'h12345678);
        start_err(32'h80, 1, 1'b0, 5'd0, 32'd0);
        wait_resume(1'b0);
        chk("t1_resume_cycle", 32'(resume_cyc - e_cyc), 35);
        check_logs("t1");
        if (log0_a.size() == 32) begin
            chk("t1_x5_addr", 32'(log0_a[4]), 32'h0414);
            chk("t1_x5_data", log0_d[4], 32'hDEADBEEF);
            chk("t1_x31_addr", 32'(log0_a[30]), 32'h047C);
            chk("t1_x31_data", log0_d[30], 32'h12345678);
            chk("t1_npc_addr", 32'(log0_a[31]), 32'h2000);
            chk("t1_npc_data", log0_d[31], 32'h80);
        end
        chk("t1_cnt", 32'(rcnt), 1);

        // Core 1 grants three cycles after core 0 on every beat
        skew1 = 3;
        rf_write(5'd9, 32'h99990000);
        start_err(32'h1000, 1, 1'b0, 5'd0, 32'd0);
        wait_resume(1'b0);
        chk("t2_resume_cycle", 32'(resume_cyc - e_cyc), 131);
        check_logs("t2");
        skew1 = 0;

        // Write coinciding with error is dropped; x0 write never lands
        rf_write(5'd7, 32'h1111);
        rf_write(5'd0, 32'hFFFF);
        start_err(32'h200, 1, 1'b1, 5'd7, 32'hAAAA);
        wait_resume(1'b0);
        check_logs("t3");
        if (log0_d.size() == 32 && log1_d.size() == 32) begin
            chk("t3_x7_core0", log0_d[6], 32'h1111);
            chk("t3_x7_core1", log1_d[6], 32'h1111);
        end

        // Asynchronous reset in the middle of beat idx 12
        start_err(32'h300, 1, 1'b0, 5'd0, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            found = (we && addr == 15'h0430);
        end
        chk("t4_reached_idx12", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_ctl", 32'({req1, req0, halt, resume, we, busy, tmo_flag}), 0);
        chk("t4_async_addr", 32'(addr), 0);
        chk("t4_async_wdata", wdata, 0);
        chk("t4_async_cnt", 32'(rcnt), 0);
        phase = 0; m_cnt = 0; m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_shadow[i] = 32'd0;
        clear_logs();
        step(); step();
        rst_n = 1'b1;
        step();
        start_err(32'h44, 1, 1'b0, 5'd0, 32'd0);
        wait_resume(1'b0);
        check_logs("t4");
        if (log0_d.size() == 32) begin
            chk("t4_x12_zero", log0_d[11], 32'h0);
            chk("t4_npc", log0_d[31], 32'h44);
        end

        // Back-to-back recoveries: counter saturation, error ignored while busy
        for (int r = 0; r < 256; r++) begin
            rf_write(5'((r % 31) + 1), 32'(r) * 32'h01010101);
            start_err(32'h4000 + 32'(r) * 4, 1, 1'b0, 5'd0, 32'd0);
            wait_resume(r == 3);
            check_logs("t5");
        end
        chk("t5_cnt_saturated", 32'(rcnt), 255);

        // Only core 0 halts: timeout, terminal failure, later error ignored
        halted1 = 1'b0;
        start_err(32'h500, 2, 1'b0, 5'd0, 32'd0);
        repeat (30) step();
        error = 1'b1;
        step();
        error = 1'b0;
        repeat (20) step();
        chk("t6_timeout", 32'(tmo_flag), 1);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_cnt_held", 32'(rcnt), 255);
        chk("t6_no_req_log", 32'(log0_a.size() + log1_a.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
